// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: MDU opcodes, FSM states and launch-op decode (madd family gated by MDU_MADD_EN)
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        mdu_none  = 4'd0,
        mdu_mult  = 4'd1,
        mdu_multu = 4'd2,
        mdu_div   = 4'd3,
        mdu_divu  = 4'd4,
        mdu_mfhi  = 4'd5,
        mdu_mflo  = 4'd6,
        mdu_mthi  = 4'd7,
        mdu_mtlo  = 4'd8,
        mdu_madd  = 4'd9,
        mdu_maddu = 4'd10,
        mdu_msub  = 4'd11,
        mdu_msubu = 4'd12
    } mdu_op_e;

    typedef enum logic {
        st_idle = 1'b0,
        st_run  = 1'b1
    } mdu_state_e;

    function automatic logic is_div(input logic [3:0] op);
        return op == mdu_div || op == mdu_divu;
    endfunction

    function automatic logic is_launch(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return op inside {mdu_mult, mdu_multu, mdu_div, mdu_divu, mdu_madd, mdu_maddu, mdu_msub, mdu_msubu};
`else
        return op inside {mdu_mult, mdu_multu, mdu_div, mdu_divu};
`endif
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle mult/div unit holding HI/LO; MDU_MADD_EN adds madd/maddu/msub/msubu
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUresult
);

    mdu_state_e  state, state_n;
    logic [4:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        launch, sgn, dv, wr;
    logic [63:0] ea, eb, prod, res;
    logic [31:0] ua, ub, ubs, uq, ur, q, r;

    assign launch = state == st_idle && Start && is_launch(MDUOp);

    // Result of the captured operation; division runs on magnitudes so the
    // 0x80000000 / -1 case falls out as LO=0x80000000, HI=0 without special handling
    always_comb begin
        sgn  = op_q == mdu_mult || op_q == mdu_div || op_q == mdu_madd || op_q == mdu_msub;
        dv   = is_div(op_q);
        ea   = {{32{sgn & a_q[31]}}, a_q};
        eb   = {{32{sgn & b_q[31]}}, b_q};
        prod = ea * eb;
        ua   = sgn && a_q[31] ? -a_q : a_q;
        ub   = sgn && b_q[31] ? -b_q : b_q;
        ubs  = ub == 32'd0 ? 32'd1 : ub;
        uq   = ua / ubs;
        ur   = ua % ubs;
        q    = sgn && (a_q[31] ^ b_q[31]) ? -uq : uq;
        r    = sgn && a_q[31] ? -ur : ur;
        res  = dv ? {r, q} : prod;
`ifdef MDU_MADD_EN
        res  = op_q == mdu_madd || op_q == mdu_maddu ? {HI, LO} + prod :
               op_q == mdu_msub || op_q == mdu_msubu ? {HI, LO} - prod : res;
`endif
        wr   = !(dv && b_q == 32'd0);
    end

    // Next state: launch from idle, return to idle when the counter expires
    always_comb begin
        state_n = state == st_idle ? (launch ? st_run : st_idle) : (cnt == 5'd0 ? st_idle : st_run);
    end

    // Outputs: busy flag and mfhi/mflo read port
    always_comb begin
        Busy      = state == st_run;
        MDUresult = MDUOp == mdu_mfhi ? HI : MDUOp == mdu_mflo ? LO : 32'd0;
    end

    // State, operand capture, latency counter and HI/LO updates
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= st_idle;
            cnt   <= 5'd0;
            op_q  <= mdu_none;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            state <= state_n;
            if (launch) begin
                op_q <= MDUOp;
                a_q  <= A;
                b_q  <= B;
                cnt  <= is_div(MDUOp) ? 5'(DIV_CYCLES - 1) : 5'(MULT_CYCLES - 1);
            end else if (state == st_run) begin
                cnt <= cnt - 5'd1;
                if (cnt == 5'd0 && wr) {HI, LO} <= res;
            end else if (MDUOp == mdu_mthi) begin
                HI <= A;
            end else if (MDUOp == mdu_mtlo) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed self-checking bench for mdu_unit
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0, B = '0;
    logic [3:0]  MDUOp = mdu_none;
    logic        Start = 1'b0;
    logic        Busy;
    logic [31:0] HI, LO, MDUresult;
    int          checks = 0;
    int          errors = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp), .Start(Start),
        .Busy(Busy), .HI(HI), .LO(LO), .MDUresult(MDUresult)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUOp = op;
        A = a;
        B = b;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        MDUOp = mdu_none;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        MDUOp = op;
        A = a;
        tick();
        MDUOp = mdu_none;
    endtask

    task automatic wait_busy(input string tag, input int n, input logic [31:0] old_hi, input logic [31:0] old_lo);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, 32'(Busy), 32'd1);
            chk({tag, "_hold_hi"}, HI, old_hi);
            chk({tag, "_hold_lo"}, LO, old_lo);
            tick();
        end
        chk({tag, "_done"}, 32'(Busy), 32'd0);
    endtask

    task automatic res(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        chk({tag, "_hi"}, HI, hi);
        chk({tag, "_lo"}, LO, lo);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(Busy), 32'd0);
        res("rst", 32'd0, 32'd0);
        chk("rst_mdures", MDUresult, 32'd0);

        go(mdu_mult, 32'hFFFF_FFFE, 32'd3);
        wait_busy("mult", 5, 32'd0, 32'd0);
        res("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        go(mdu_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_busy("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        res("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        go(mdu_divu, 32'd7, 32'd2);
        wait_busy("divu", 10, 32'hFFFF_FFFE, 32'h0000_0001);
        res("divu", 32'd1, 32'd3);

        go(mdu_div, 32'hFFFF_FFF9, 32'd2);
        wait_busy("div", 10, 32'd1, 32'd3);
        res("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        mt(mdu_mthi, 32'h11);
        mt(mdu_mtlo, 32'h22);
        res("mtx", 32'h11, 32'h22);
        go(mdu_div, 32'd5, 32'd0);
        wait_busy("div0", 10, 32'h11, 32'h22);
        res("div0", 32'h11, 32'h22);

        go(mdu_div, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy("divovf", 10, 32'h11, 32'h22);
        res("divovf", 32'd0, 32'h8000_0000);

        mt(mdu_mthi, 32'hDEAD_BEEF);
        chk("mthi", HI, 32'hDEAD_BEEF);
        MDUOp = mdu_mfhi;
        #1;
        chk("mfhi", MDUresult, 32'hDEAD_BEEF);
        MDUOp = mdu_mflo;
        #1;
        chk("mflo", MDUresult, 32'h8000_0000);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("nonlaunch_busy", 32'(Busy), 32'd0);
        MDUOp = mdu_none;
        #1;
        chk("none_mdures", MDUresult, 32'd0);

        go(mdu_mult, 32'd3, 32'd4);
        mt(mdu_mtlo, 32'h55);
        wait_busy("mtlo_busy", 4, 32'hDEAD_BEEF, 32'h8000_0000);
        res("mtlo_busy", 32'd0, 32'hC);

        go(mdu_mult, 32'd3, 32'd5);
        tick();
        go(mdu_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_busy("restart", 3, 32'd0, 32'hC);
        res("restart", 32'd0, 32'hF);

        go(mdu_div, 32'd100, 32'd7);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        res("abort", 32'd0, 32'd0);
        repeat (12) tick();
        chk("abort_late_busy", 32'(Busy), 32'd0);
        res("abort_late", 32'd0, 32'd0);

        mt(mdu_mtlo, 32'hFFFF_FFFF);
        go(mdu_maddu, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_busy("maddu", 5, 32'd0, 32'hFFFF_FFFF);
        res("maddu", 32'd1, 32'd0);
        go(mdu_msub, 32'd2, 32'hFFFF_FFFF);
        wait_busy("msub", 5, 32'd1, 32'd0);
        res("msub", 32'd1, 32'd2);
`else
        chk("maddu_off_busy", 32'(Busy), 32'd0);
        repeat (6) tick();
        chk("maddu_off_late_busy", 32'(Busy), 32'd0);
        res("maddu_off", 32'd0, 32'hFFFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
